pipe_ctrl: RTL and testbench

- Central sequencer for the 5-stage MIPS pipeline: owns every stage-advance, flush and bubble enable.
- Resolves load-use stalls, branch-mispredict flushes, halt-instruction drain, and debug run/pause/single-step from one FSM.
- Sits beside the pipeline top. Drives PC, IF/ID, ID/EX and the back-end latches (EX/MEM, MEM/WB, regfile write gate).
- Takes hazard/status inputs from the ID and EX stages.

---
 rtl/pipe_ctrl.sv | 74 +++++++
 tb/tb_pipe_ctrl.sv | 114 +++++++++++
 2 files changed

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: 5-stage pipeline sequencer (stall/flush/drain/debug FSM); counters built only with PIPE_CTRL_PERF_EN
module pipe_ctrl #(
  parameter int DRAIN_CYCLES = 3,
  parameter int COUNT_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               i_start,
  input  logic               i_step,
  input  logic               i_halt_req,
  input  logic               i_load_use,
  input  logic               i_mispredicted,
  input  logic               i_halt_detect,
  output logic               o_pc_en,
  output logic               o_if_id_en,
  output logic               o_if_id_flush,
  output logic               o_id_ex_flush,
  output logic               o_pipe_en,
  output logic [2:0]         o_state,
  output logic               o_halted,
  output logic [COUNT_W-1:0] o_cycle_count,
  output logic [COUNT_W-1:0] o_stall_count
);
  typedef enum logic [2:0] {IDLE = 3'd0, RUN = 3'd1, STEP = 3'd2, DRAIN = 3'd3, HALTED = 3'd4} state_t;
  localparam int DW = DRAIN_CYCLES > 1 ? $clog2(DRAIN_CYCLES) : 1;
  state_t state, state_nx;
  logic [DW-1:0] drain;
  logic act, hold, mp, hd, lu, in_drain;
  assign act = state == RUN || state == STEP;
  assign in_drain = state == DRAIN;
  assign hold = state == RUN && i_halt_req;
  assign mp = act && !hold && i_mispredicted;
  assign hd = act && !hold && !i_mispredicted && i_halt_detect;
  assign lu = act && !hold && !i_mispredicted && !i_halt_detect && i_load_use;
  assign o_pc_en = act && !hold && !hd && !lu;
  assign o_if_id_en = o_pc_en;
  assign o_if_id_flush = mp;
  assign o_id_ex_flush = mp || hd || lu || in_drain;
  assign o_pipe_en = (act && !hold) || in_drain;
  assign o_state = state;
  assign o_halted = state == HALTED;
  always_comb begin
    state_nx = state == IDLE ? (i_start ? RUN : i_step ? STEP : IDLE) :
               state == RUN  ? (hold ? IDLE : hd ? DRAIN : RUN) :
               state == STEP ? (hd ? DRAIN : IDLE) :
               state == DRAIN ? (drain == '0 ? HALTED : DRAIN) : HALTED;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) drain <= '0;
    else if (hd) drain <= DW'(DRAIN_CYCLES - 1);
    else if (in_drain && drain != '0) drain <= drain - DW'(1);
  end
`ifdef PIPE_CTRL_PERF_EN
  logic [COUNT_W-1:0] cyc, stall;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cyc <= '0;
      stall <= '0;
    end else begin
      cyc <= cyc + COUNT_W'(o_pipe_en);
      stall <= stall + COUNT_W'(lu);
    end
  end
  assign o_cycle_count = cyc;
  assign o_stall_count = stall;
`else
  assign o_cycle_count = '0;
  assign o_stall_count = '0;
`endif
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: scoreboarded random and directed test of pipe_ctrl against a rule-level model
module tb_pipe_ctrl;
  localparam int DC = 3;
  typedef struct packed {
    logic [8:0]  ctl;
    logic [31:0] cyc;
    logic [31:0] stall;
  } exp_t;
  logic clk = 0, reset = 0, i_start = 0, i_step = 0, i_halt_req = 0;
  logic i_load_use = 0, i_mispredicted = 0, i_halt_detect = 0;
  logic o_pc_en, o_if_id_en, o_if_id_flush, o_id_ex_flush, o_pipe_en, o_halted;
  logic [2:0] o_state;
  logic [31:0] o_cycle_count, o_stall_count;
  exp_t q[$];
  int tests = 0, fails = 0;
  int ms = 0, mrem = 0;
  bit [31:0] mcyc = 0, mstall = 0;
  pipe_ctrl #(.DRAIN_CYCLES(DC), .COUNT_W(32)) dut (
    .clk(clk), .reset(reset), .i_start(i_start), .i_step(i_step), .i_halt_req(i_halt_req),
    .i_load_use(i_load_use), .i_mispredicted(i_mispredicted), .i_halt_detect(i_halt_detect),
    .o_pc_en(o_pc_en), .o_if_id_en(o_if_id_en), .o_if_id_flush(o_if_id_flush),
    .o_id_ex_flush(o_id_ex_flush), .o_pipe_en(o_pipe_en), .o_state(o_state), .o_halted(o_halted),
    .o_cycle_count(o_cycle_count), .o_stall_count(o_stall_count)
  );
  always #5 clk = ~clk;
  task automatic cyc(input bit s, st, hr, lu, mp, hd, r);
    bit pc, fi, ff, fd, pe, stl;
    int nx;
    exp_t e;
    @(negedge clk);
    reset = r; i_start = s; i_step = st; i_halt_req = hr;
    i_load_use = lu; i_mispredicted = mp; i_halt_detect = hd;
    {pc, fi, ff, fd, pe, stl} = '0;
    nx = ms;
    if (r) begin
      ms = 0; mrem = 0; mcyc = 0; mstall = 0; nx = 0;
    end else if (ms == 0) nx = s ? 1 : st ? 2 : 0;
    else if (ms == 1 || ms == 2) begin
      if (ms == 1 && hr) nx = 0;
      else begin
        pe = 1;
        nx = ms == 1 ? 1 : 0;
        if (mp) {pc, fi, ff, fd} = 4'b1111;
        else if (hd) begin fd = 1; nx = 3; mrem = DC; end
        else if (lu) begin fd = 1; stl = 1; end
        else {pc, fi} = 2'b11;
      end
    end else if (ms == 3) begin
      fd = 1; pe = 1; mrem--;
      nx = mrem == 0 ? 4 : 3;
    end
    e.ctl = {pc, fi, ff, fd, pe, 3'(ms), ms == 4};
`ifdef PIPE_CTRL_PERF_EN
    e.cyc = mcyc; e.stall = mstall;
`else
    e.cyc = 0; e.stall = 0;
`endif
    q.push_back(e);
    if (!r) begin
      mcyc += 32'(pe); mstall += 32'(stl); ms = nx;
    end
  endtask
  initial begin
    exp_t e;
    logic [8:0] got;
    forever begin
      @(negedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        got = {o_pc_en, o_if_id_en, o_if_id_flush, o_id_ex_flush, o_pipe_en, o_state, o_halted};
        tests += 3;
        if (got !== e.ctl) begin fails++; $display("FAIL ctl t=%0t got %b exp %b", $time, got, e.ctl); end
        if (o_cycle_count !== e.cyc) begin fails++; $display("FAIL cycle_count t=%0t got %0d exp %0d", $time, o_cycle_count, e.cyc); end
        if (o_stall_count !== e.stall) begin fails++; $display("FAIL stall_count t=%0t got %0d exp %0d", $time, o_stall_count, e.stall); end
      end
    end
  end
  initial begin
    cyc(0,0,0,0,0,0,1);
    cyc(1,0,0,0,0,0,0);
    repeat (10) cyc(0,0,0,0,0,0,0);
    cyc(0,0,0,1,0,0,0);
    cyc(0,0,0,0,0,0,0);
    cyc(0,0,0,1,1,0,0);
    cyc(0,0,0,0,0,0,0);
    cyc(0,0,1,0,1,0,0);
    cyc(1,0,0,0,0,0,0);
    cyc(0,0,0,0,0,1,0);
    repeat (5) cyc(1,1,1,1,1,0,0);
    cyc(0,0,0,0,0,0,1);
    repeat (3) begin
      cyc(0,1,0,0,0,0,0);
      repeat (2) cyc(0,0,0,0,0,0,0);
    end
    cyc(0,1,1,0,0,1,0);
    repeat (5) cyc(0,1,0,1,1,0,0);
    cyc(0,0,0,0,0,0,1);
    repeat (3000) begin
      automatic bit r = ms == 4 ? $urandom_range(99) < 20 : $urandom_range(199) == 0;
      cyc($urandom_range(99) < 15, $urandom_range(99) < 20, $urandom_range(99) < 8,
          $urandom_range(99) < 20, $urandom_range(99) < 12, $urandom_range(99) < 3, r);
    end
    cyc(0,0,0,0,0,0,1);
    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    #5;
    if (q.size() > 0) begin
      tests++; fails++;
      $display("FAIL drain_queue left %0d exp 0", q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
